// File: rtl/riscv_pkg.sv
// Shared RV64 pipeline definitions: widths, fetch FSM
// states and the PC helpers used by the fetch stage.
package riscv_pkg;

    localparam int XLEN   = 64;
    localparam int INSN_W = 32;

    localparam logic [XLEN-1:0] DEF_RESET_PC = 64'h0;
    localparam logic [XLEN-1:0] PC_INC       = 64'd4;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fe_state_t;

    // Force a target onto a word boundary.
    function automatic logic [XLEN-1:0] align_pc(
        input logic [XLEN-1:0] a
    );
        return a & ~64'd3;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory request/ack channel between the
// fetch stage (master) and instruction memory (slave).
interface fetch_stage_if;
    import riscv_pkg::*;

    logic              IMEM_REQ;
    logic [XLEN-1:0]   IMEM_ADDR;
    logic              IMEM_ACK;
    logic [INSN_W-1:0] IMEM_RDATA;

    modport master (
        output IMEM_REQ,
        output IMEM_ADDR,
        input  IMEM_ACK,
        input  IMEM_RDATA
    );

    modport slave (
        input  IMEM_REQ,
        input  IMEM_ADDR,
        output IMEM_ACK,
        output IMEM_RDATA
    );

endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry IR/NPC holding register with valid flag,
// used when decode cannot take a word memory returned.
module fetch_skid_buffer
    import riscv_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [INSN_W-1:0] ir_in,
    input  logic [XLEN-1:0]   npc_in,
    output logic              valid,
    output logic [INSN_W-1:0] ir,
    output logic [XLEN-1:0]   npc
);

    // Capture on push; flush beats everything, pop drains.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid <= 1'b0;
            ir    <= '0;
            npc   <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (push) begin
            valid <= 1'b1;
            ir    <= ir_in;
            npc   <= npc_in;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV64 instruction fetch stage: owns the PC, drives the
// DE latch. Optional skid buffer under FETCH_SKID_EN.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC
) (
    input  logic              CLK,
    input  logic              RST_N,
    fetch_stage_if.master     imem,
    input  logic              LD_DE,
    input  logic              DE_BR_STALL,
    input  logic              EXE_BR_STALL,
    input  logic              MEM_BR_STALL,
    input  logic              BR_REDIRECT,
    input  logic [XLEN-1:0]   BR_TARGET,
    output logic [XLEN-1:0]   DE_NPC,
    output logic [INSN_W-1:0] DE_IR,
    output logic              DE_V,
    output logic [XLEN-1:0]   FE_PC
);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_inc;
    logic            stall_any;
    logic            req;
    logic            deliver;

    assign stall_any = DE_BR_STALL | EXE_BR_STALL
                     | MEM_BR_STALL;
    assign pc_inc    = pc + PC_INC;
    assign deliver   = req & imem.IMEM_ACK;

    assign imem.IMEM_REQ  = req;
    assign imem.IMEM_ADDR = pc;
    assign FE_PC          = pc;

`ifdef FETCH_SKID_EN
    fe_state_t         state;
    logic              push;
    logic              pop;
    logic              skid_v;
    logic [INSN_W-1:0] skid_ir;
    logic [XLEN-1:0]   skid_npc;

    // Decode back-pressure does not stop fetch here;
    // only a full skid (HOLD) does.
    assign req  = (state == FETCH) & ~stall_any
                & ~BR_REDIRECT;
    assign push = deliver & ~LD_DE;
    assign pop  = (state == HOLD) & skid_v & LD_DE
                & ~BR_REDIRECT;

    fetch_skid_buffer u_skid (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .push   (push),
        .pop    (pop),
        .flush  (BR_REDIRECT),
        .ir_in  (imem.IMEM_RDATA),
        .npc_in (pc_inc),
        .valid  (skid_v),
        .ir     (skid_ir),
        .npc    (skid_npc)
    );

    // FETCH/HOLD sequencing; redirect always returns to FETCH.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= FETCH;
        end else if (BR_REDIRECT) begin
            state <= FETCH;
        end else if (push) begin
            state <= HOLD;
        end else if (pop) begin
            state <= FETCH;
        end
    end
`else
    // Without a skid, a word may only be fetched when
    // decode can take it in the same cycle.
    assign req = ~stall_any & ~BR_REDIRECT & LD_DE;
`endif

    // PC: redirect wins, otherwise advance on delivery.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc <= RESET_PC;
        end else if (BR_REDIRECT) begin
            pc <= align_pc(BR_TARGET);
        end else if (deliver) begin
            pc <= pc_inc;
        end
    end

    // DE latch: load word, skid entry, or a bubble.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            DE_V   <= 1'b0;
            DE_IR  <= '0;
            DE_NPC <= '0;
        end else if (BR_REDIRECT) begin
            if (LD_DE) begin
                DE_V <= 1'b0;
            end
        end else if (deliver && LD_DE) begin
            DE_V   <= 1'b1;
            DE_IR  <= imem.IMEM_RDATA;
            DE_NPC <= pc_inc;
`ifdef FETCH_SKID_EN
        end else if (pop) begin
            DE_V   <= 1'b1;
            DE_IR  <= skid_ir;
            DE_NPC <= skid_npc;
`endif
        end else if (LD_DE) begin
            DE_V <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios
// plus randomized traffic against a behavioural model.
module tb_fetch_stage;
    import riscv_pkg::*;

    localparam logic [63:0] RPC = 64'h0;
`ifdef FETCH_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        LD_DE;
    logic        DE_BR_STALL;
    logic        EXE_BR_STALL;
    logic        MEM_BR_STALL;
    logic        BR_REDIRECT;
    logic [63:0] BR_TARGET;
    logic [63:0] DE_NPC;
    logic [31:0] DE_IR;
    logic        DE_V;
    logic [63:0] FE_PC;

    fetch_stage_if imem ();

    fetch_stage #(.RESET_PC(RPC)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .imem         (imem),
        .LD_DE        (LD_DE),
        .DE_BR_STALL  (DE_BR_STALL),
        .EXE_BR_STALL (EXE_BR_STALL),
        .MEM_BR_STALL (MEM_BR_STALL),
        .BR_REDIRECT  (BR_REDIRECT),
        .BR_TARGET    (BR_TARGET),
        .DE_NPC       (DE_NPC),
        .DE_IR        (DE_IR),
        .DE_V         (DE_V),
        .FE_PC        (FE_PC)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [63:0] m_pc;
    logic        m_dv;
    logic [31:0] m_ir;
    logic [63:0] m_npc;
    logic        m_sv;
    logic [31:0] m_sir;
    logic [63:0] m_snpc;

    logic        obs_req;
    logic [63:0] obs_addr;
    logic        exp_req;
    logic [63:0] exp_addr;

    // Instruction memory contents as a pure function of address.
    function automatic logic [31:0] memf(input logic [63:0] a);
        logic [31:0] lo;
        lo = a[31:0];
        return (lo * 32'd2654435761) ^ 32'h0000_0013;
    endfunction

    task automatic model_reset();
        m_pc  = RPC;
        m_dv  = 1'b0;
        m_ir  = 32'h0;
        m_npc = 64'h0;
        m_sv  = 1'b0;
        m_sir = 32'h0;
        m_snpc = 64'h0;
    endtask

    task automatic idle_inputs();
        LD_DE        = 1'b0;
        DE_BR_STALL  = 1'b0;
        EXE_BR_STALL = 1'b0;
        MEM_BR_STALL = 1'b0;
        BR_REDIRECT  = 1'b0;
        BR_TARGET    = 64'h0;
        imem.IMEM_ACK   = 1'b0;
        imem.IMEM_RDATA = 32'h0;
    endtask

    // Reset held for two edges, released at posedge+1.
    task automatic do_reset();
        RST_N = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
    endtask

    // One clock cycle of stimulus; updates the model.
    task automatic drive_cycle(
        input logic ld, input logic ds,
        input logic es, input logic ms,
        input logic rd, input logic [63:0] tgt,
        input logic ack
    );
        logic stall;
        logic [31:0] w;
        @(negedge CLK);
        LD_DE        = ld;
        DE_BR_STALL  = ds;
        EXE_BR_STALL = es;
        MEM_BR_STALL = ms;
        BR_REDIRECT  = rd;
        BR_TARGET    = tgt;
        imem.IMEM_ACK = ack;
        #1 imem.IMEM_RDATA = memf(imem.IMEM_ADDR);
        #1;
        obs_req  = imem.IMEM_REQ;
        obs_addr = imem.IMEM_ADDR;
        stall    = ds | es | ms;
        exp_req  = !m_sv && !stall && !rd && (SKID || ld);
        exp_addr = m_pc;
        @(posedge CLK);
        if (rd) begin
            m_pc = {tgt[63:2], 2'b00};
            m_sv = 1'b0;
            if (ld) m_dv = 1'b0;
        end else if (exp_req && ack) begin
            w = memf(m_pc);
            if (ld) begin
                m_ir  = w;
                m_npc = m_pc + 64'd4;
                m_dv  = 1'b1;
            end else begin
                m_sv   = 1'b1;
                m_sir  = w;
                m_snpc = m_pc + 64'd4;
            end
            m_pc = m_pc + 64'd4;
        end else if (ld) begin
            if (m_sv) begin
                m_ir  = m_sir;
                m_npc = m_snpc;
                m_dv  = 1'b1;
                m_sv  = 1'b0;
            end else begin
                m_dv = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (DE_V !== 1'b0) begin
            failures++;
            $display("FAIL reset_de_v got=%b exp=0", DE_V);
        end
        checks++;
        if (DE_IR !== 32'h0) begin
            failures++;
            $display("FAIL reset_de_ir got=%h exp=0", DE_IR);
        end
        checks++;
        if (DE_NPC !== 64'h0) begin
            failures++;
            $display("FAIL reset_de_npc got=%h exp=0", DE_NPC);
        end
        checks++;
        if (FE_PC !== RPC) begin
            failures++;
            $display("FAIL reset_fe_pc got=%h exp=%h", FE_PC, RPC);
        end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1, 0, 0, 0, 0, 64'h0, 1);
            checks++;
            if (obs_req !== 1'b1 || obs_addr !== 64'(i * 4)) begin
                failures++;
                $display("FAIL seq_req req=%b addr=%h exp=1/%h",
                         obs_req, obs_addr, 64'(i * 4));
            end
            checks++;
            if (DE_V !== 1'b1 || DE_NPC !== 64'(i * 4 + 4)) begin
                failures++;
                $display("FAIL seq_de v=%b npc=%h exp=1/%h",
                         DE_V, DE_NPC, 64'(i * 4 + 4));
            end
            checks++;
            if (DE_IR !== memf(64'(i * 4))) begin
                failures++;
                $display("FAIL seq_ir got=%h exp=%h",
                         DE_IR, memf(64'(i * 4)));
            end
        end
    endtask

    task automatic test_stall_redirect();
        logic [2:0] st;
        for (int i = 0; i < 3; i++) begin
            st = 3'b001 << i;
            drive_cycle(1, st[0], st[1], st[2], i == 2,
                        64'h102, 1);
            checks++;
            if (obs_req !== 1'b0 || DE_V !== 1'b0) begin
                failures++;
                $display("FAIL stall_bubble req=%b v=%b exp=0/0",
                         obs_req, DE_V);
            end
        end
        drive_cycle(1, 0, 0, 0, 0, 64'h0, 1);
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== 64'h100) begin
            failures++;
            $display("FAIL stall_resume req=%b addr=%h exp=1/100",
                     obs_req, obs_addr);
        end
        checks++;
        if (DE_V !== 1'b1 || DE_NPC !== 64'h104) begin
            failures++;
            $display("FAIL stall_resume_de v=%b npc=%h exp=1/104",
                     DE_V, DE_NPC);
        end
    endtask

    task automatic test_ack_low();
        drive_cycle(1, 0, 0, 0, 1, 64'h8, 1);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1, 0, 0, 0, 0, 64'h0, 0);
            checks++;
            if (obs_addr !== 64'h8 || DE_V !== 1'b0) begin
                failures++;
                $display("FAIL ack_low addr=%h v=%b exp=8/0",
                         obs_addr, DE_V);
            end
        end
        drive_cycle(1, 0, 0, 0, 0, 64'h0, 1);
        checks++;
        if (DE_V !== 1'b1 || DE_NPC !== 64'hC) begin
            failures++;
            $display("FAIL ack_resume v=%b npc=%h exp=1/c",
                     DE_V, DE_NPC);
        end
    endtask

    task automatic test_redirect_ack();
        drive_cycle(1, 0, 0, 0, 1, 64'h2000, 1);
        checks++;
        if (DE_V !== 1'b0 || FE_PC !== 64'h2000) begin
            failures++;
            $display("FAIL redir_ack v=%b pc=%h exp=0/2000",
                     DE_V, FE_PC);
        end
        drive_cycle(1, 0, 0, 0, 0, 64'h0, 1);
        checks++;
        if (obs_addr !== 64'h2000 || DE_NPC !== 64'h2004) begin
            failures++;
            $display("FAIL redir_next addr=%h npc=%h exp=2000/2004",
                     obs_addr, DE_NPC);
        end
    endtask

    task automatic test_wrap();
        drive_cycle(1, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        drive_cycle(1, 0, 0, 0, 0, 64'h0, 1);
        checks++;
        if (obs_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_addr got=%h exp=fffffffffffffffc",
                     obs_addr);
        end
        checks++;
        if (DE_NPC !== 64'h0 || DE_V !== 1'b1 || FE_PC !== 64'h0)
        begin
            failures++;
            $display("FAIL wrap_npc npc=%h v=%b pc=%h exp=0/1/0",
                     DE_NPC, DE_V, FE_PC);
        end
    endtask

`ifdef FETCH_SKID_EN
    task automatic test_skid();
        drive_cycle(1, 0, 0, 0, 1, 64'h8, 0);
        drive_cycle(0, 0, 0, 0, 0, 64'h0, 1);
        checks++;
        if (obs_req !== 1'b1 || DE_V !== 1'b0) begin
            failures++;
            $display("FAIL skid_push req=%b v=%b exp=1/0",
                     obs_req, DE_V);
        end
        drive_cycle(0, 0, 0, 0, 0, 64'h0, 1);
        checks++;
        if (obs_req !== 1'b0 || DE_V !== 1'b0) begin
            failures++;
            $display("FAIL skid_hold req=%b v=%b exp=0/0",
                     obs_req, DE_V);
        end
        drive_cycle(1, 0, 0, 0, 0, 64'h0, 1);
        checks++;
        if (DE_V !== 1'b1 || DE_IR !== memf(64'h8)
            || DE_NPC !== 64'hC) begin
            failures++;
            $display("FAIL skid_pop v=%b ir=%h npc=%h exp=1/%h/c",
                     DE_V, DE_IR, DE_NPC, memf(64'h8));
        end
        drive_cycle(1, 0, 0, 0, 0, 64'h0, 1);
        checks++;
        if (obs_addr !== 64'hC) begin
            failures++;
            $display("FAIL skid_next got=%h exp=c", obs_addr);
        end
    endtask
`endif

    // Reset mid-operation (mid-HOLD in the skid build).
    task automatic test_reset_mid();
        drive_cycle(1, 0, 0, 0, 1, 64'h40, 0);
        drive_cycle(1, 0, 0, 0, 0, 64'h0, 1);
        drive_cycle(SKID ? 1'b0 : 1'b1, 0, 0, 0, 0, 64'h0, 1);
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        checks++;
        if (DE_V !== 1'b0 || FE_PC !== RPC
            || imem.IMEM_ADDR !== RPC) begin
            failures++;
            $display("FAIL reset_mid v=%b pc=%h addr=%h exp=0/%h",
                     DE_V, FE_PC, imem.IMEM_ADDR, RPC);
        end
        do_reset();
        drive_cycle(1, 0, 0, 0, 0, 64'h0, 1);
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== RPC
            || DE_NPC !== RPC + 64'd4) begin
            failures++;
            $display("FAIL reset_mid_resume req=%b addr=%h npc=%h",
                     obs_req, obs_addr, DE_NPC);
        end
    endtask

    task automatic test_random();
        logic ld, ds, es, ms, rd, ack;
        logic [63:0] tgt;
        for (int i = 0; i < 400; i++) begin
            ld  = ($urandom_range(0, 3) != 0);
            ds  = ($urandom_range(0, 9) == 0);
            es  = ($urandom_range(0, 9) == 0);
            ms  = ($urandom_range(0, 9) == 0);
            rd  = ($urandom_range(0, 15) == 0);
            ack = ($urandom_range(0, 3) != 0);
            tgt = {$urandom, $urandom};
            drive_cycle(ld, ds, es, ms, rd, tgt, ack);
            checks++;
            if (obs_req !== exp_req || obs_addr !== exp_addr) begin
                failures++;
                $display("FAIL rnd_req cyc=%0d req=%b addr=%h exp=%b/%h",
                         i, obs_req, obs_addr, exp_req, exp_addr);
            end
            checks++;
            if (DE_V !== m_dv || DE_IR !== m_ir
                || DE_NPC !== m_npc || FE_PC !== m_pc) begin
                failures++;
                $display("FAIL rnd_de cyc=%0d v=%b ir=%h npc=%h pc=%h exp=%b/%h/%h/%h",
                         i, DE_V, DE_IR, DE_NPC, FE_PC,
                         m_dv, m_ir, m_npc, m_pc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_redirect();
        test_ack_low();
        test_redirect_ack();
        test_wrap();
`ifdef FETCH_SKID_EN
        test_skid();
`endif
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
